// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and parity modes.
// Used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int SAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Tick counter must hold SAMPLE-1 as well as SB_TICK-1.
  function automatic int tick_cnt_w(input int sb_tick);
    return ($clog2(sb_tick) < 4) ? 4 : $clog2(sb_tick);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_SIZE data bits LSB-first, optional parity, stop period.
// Bit timing counts the external 16x oversampling strobe s_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int SB_TICK   = 16,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 tx_start,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int TW = tick_cnt_w(SB_TICK);
  localparam int BW = $clog2(DATA_SIZE + 1);

  uart_state_e          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_SIZE-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;
  logic                 stop_end;
  logic                 last_bit;

  assign bit_end  = (tick_cnt == TW'(SAMPLE - 1));
  assign stop_end = (tick_cnt == TW'(SB_TICK - 1));
  assign last_bit = (bit_cnt == BW'(DATA_SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          // A strobe coinciding with accept is deliberately not counted.
          if (tx_start) begin
            shreg    <= data_in;
            par_bit  <= (^data_in) ^ (PARITY == PAR_ODD);
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= S_START;
          end
        end

        S_START: begin
          if (s_tick) begin
            if (bit_end) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              tx       <= shreg[0];
              state    <= S_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_DATA: begin
          if (s_tick) begin
            if (bit_end) begin
              tick_cnt <= '0;
              shreg    <= shreg >> 1;
              bit_cnt  <= bit_cnt + BW'(1);
              // tx is registered, so drive the next bit's value at the boundary.
              if (last_bit) begin
                if (PARITY != PAR_NONE) begin
                  tx    <= par_bit;
                  state <= S_PARITY;
                end else begin
                  tx    <= 1'b1;
                  state <= S_STOP;
                end
              end else begin
                tx <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_PARITY: begin
          if (s_tick) begin
            if (bit_end) begin
              tick_cnt <= '0;
              tx       <= 1'b1;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (stop_end) begin
              tick_cnt     <= '0;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
              state        <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances covering no/even/odd parity and a 2-stop-bit frame.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DVSR = 27;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       start [4];
  logic [7:0] din   [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       done  [4];

  int     nvec = 0;
  int     nerr = 0;
  longint cyc = 0;
  int     tdiv = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 16x strobe every DVSR clocks, changing on the falling edge.
  always @(negedge clk) begin
    tdiv   <= (tdiv == DVSR - 1) ? 0 : tdiv + 1;
    s_tick <= tick_en && (tdiv == DVSR - 1);
  end

  uart_tx #(.DATA_SIZE(8), .SB_TICK(16), .PARITY(PAR_NONE)) u_p0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[0]), .data_in(din[0]),
    .tx(tx[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]));
  uart_tx #(.DATA_SIZE(8), .SB_TICK(16), .PARITY(PAR_EVEN)) u_pe (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[1]), .data_in(din[1]),
    .tx(tx[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]));
  uart_tx #(.DATA_SIZE(8), .SB_TICK(16), .PARITY(PAR_ODD)) u_po (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[2]), .data_in(din[2]),
    .tx(tx[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]));
  uart_tx #(.DATA_SIZE(8), .SB_TICK(32), .PARITY(PAR_NONE)) u_s2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[3]), .data_in(din[3]),
    .tx(tx[3]), .tx_busy(busy[3]), .tx_done_tick(done[3]));

  // Pulse tx_start for one edge, then scramble data_in to prove it was captured.
  task automatic accept(input int i, input logic [7:0] d);
    @(negedge clk);
    din[i]   = d;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    din[i]   = ~d;
  endtask

  // Follow one frame from the edge after accept: mid-bit line samples, boundary times, done tick.
  task automatic watch(input int i, input int stop_n, output logic [15:0] bits,
                       output int done_at, output int busy_err, output longint t16,
                       output longint t32, output longint t_stop, output longint t_done);
    int   n = 0;
    int   guard = 0;
    logic t;
    bits = '0; done_at = -1; busy_err = 0;
    t16 = 0; t32 = 0; t_stop = 0; t_done = 0;
    while (done_at < 0 && guard < DVSR * (stop_n + 48)) begin
      @(posedge clk);
      t = s_tick;
      #1;
      guard++;
      if (t) begin
        n++;
        if (n % 16 == 8 && n / 16 < 16) bits[n/16] = tx[i];
        if (n == 16) t16 = cyc;
        if (n == 32) t32 = cyc;
        if (n == stop_n) t_stop = cyc;
      end
      if (done[i]) begin
        done_at = n;
        t_done  = cyc;
      end else if (!busy[i]) begin
        busy_err++;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if ({tx[i], busy[i], done[i]} !== 3'b100) begin
        nerr++;
        $display("FAIL reset_state dut%0d: got tx/busy/done=%b want 100", i, {tx[i], busy[i], done[i]});
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    accept(0, 8'hB3);
    nvec++;
    if ({tx[0], busy[0]} !== 2'b01) begin
      nerr++; $display("FAIL accept_latency: got tx/busy=%b want 01", {tx[0], busy[0]});
    end
    watch(0, 144, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[9:0] !== {1'b1, 8'hB3, 1'b0}) begin
      nerr++; $display("FAIL basic_bits: got %b want %b", b[9:0], {1'b1, 8'hB3, 1'b0});
    end
    nvec++;
    if (da !== 160) begin nerr++; $display("FAIL basic_done_tick: got %0d want 160", da); end
    nvec++;
    if (be !== 0) begin nerr++; $display("FAIL basic_busy: got %0d low cycles want 0", be); end
    nvec++;
    if (t32 - t16 !== 64'(16 * DVSR)) begin
      nerr++; $display("FAIL basic_bit_len: got %0d want %0d", t32 - t16, 16 * DVSR);
    end
    nvec++;
    if (td - ts !== 64'(16 * DVSR)) begin
      nerr++; $display("FAIL basic_stop_len: got %0d want %0d", td - ts, 16 * DVSR);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pats [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    for (int k = 0; k < 4; k++) begin
      accept(0, pats[k]);
      watch(0, 144, b, da, be, t16, t32, ts, td);
      nvec++;
      if (b[9:0] !== {1'b1, pats[k], 1'b0} || da !== 160) begin
        nerr++;
        $display("FAIL pattern_%h: got bits %b done@%0d want %b done@160",
                 pats[k], b[9:0], da, {1'b1, pats[k], 1'b0});
      end
    end
  endtask

  task automatic test_parity();
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    accept(1, 8'hB3);
    watch(1, 160, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[10:0] !== {1'b1, 1'b1, 8'hB3, 1'b0}) begin
      nerr++; $display("FAIL parity_even_bits: got %b want %b", b[10:0], {1'b1, 1'b1, 8'hB3, 1'b0});
    end
    nvec++;
    if (da !== 176) begin nerr++; $display("FAIL parity_even_len: got %0d want 176", da); end
    accept(2, 8'hB3);
    watch(2, 160, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[10:0] !== {1'b1, 1'b0, 8'hB3, 1'b0}) begin
      nerr++; $display("FAIL parity_odd_bits: got %b want %b", b[10:0], {1'b1, 1'b0, 8'hB3, 1'b0});
    end
    nvec++;
    if (da !== 176) begin nerr++; $display("FAIL parity_odd_len: got %0d want 176", da); end
  endtask

  task automatic test_stop32();
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    accept(3, 8'hB3);
    watch(3, 144, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[9:0] !== {1'b1, 8'hB3, 1'b0} || da !== 176) begin
      nerr++; $display("FAIL stop32_frame: got bits %b done@%0d want %b done@176",
                       b[9:0], da, {1'b1, 8'hB3, 1'b0});
    end
    nvec++;
    if (td - ts !== 64'(32 * DVSR)) begin
      nerr++; $display("FAIL stop32_len: got %0d want %0d", td - ts, 32 * DVSR);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    accept(0, 8'hB3);
    // Hold a new request from mid-DATA through the done cycle.
    fork
      watch(0, 144, b, da, be, t16, t32, ts, td);
      begin
        repeat (DVSR * 64) @(negedge clk);
        din[0]   = 8'h55;
        start[0] = 1'b1;
      end
    join
    nvec++;
    if (b[9:0] !== {1'b1, 8'hB3, 1'b0} || da !== 160) begin
      nerr++; $display("FAIL busy_ignore: got bits %b done@%0d want %b done@160",
                       b[9:0], da, {1'b1, 8'hB3, 1'b0});
    end
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    din[0]   = 8'hAA;
    nvec++;
    if ({tx[0], busy[0]} !== 2'b01) begin
      nerr++; $display("FAIL b2b_accept: got tx/busy=%b want 01", {tx[0], busy[0]});
    end
    watch(0, 144, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[9:0] !== {1'b1, 8'h55, 1'b0} || da !== 160) begin
      nerr++; $display("FAIL b2b_frame: got bits %b done@%0d want %b done@160",
                       b[9:0], da, {1'b1, 8'h55, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    int stray = 0;
    accept(0, 8'hB3);
    repeat (DVSR * 72) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if ({tx[0], busy[0], done[0]} !== 3'b100) begin
      nerr++; $display("FAIL reset_mid: got tx/busy/done=%b want 100", {tx[0], busy[0], done[0]});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (DVSR * 40) begin
      @(negedge clk);
      if (done[0] || busy[0] || !tx[0]) stray++;
    end
    nvec++;
    if (stray !== 0) begin nerr++; $display("FAIL reset_no_done: got %0d bad cycles want 0", stray); end
    accept(0, 8'h0F);
    watch(0, 144, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[9:0] !== {1'b1, 8'h0F, 1'b0} || da !== 160) begin
      nerr++; $display("FAIL reset_recover: got bits %b done@%0d want %b done@160",
                       b[9:0], da, {1'b1, 8'h0F, 1'b0});
    end
  endtask

  task automatic test_no_tick();
    logic [15:0] b; int da, be; longint t16, t32, ts, td;
    @(negedge clk);
    tick_en = 1'b0;
    accept(0, 8'h5A);
    repeat (3000) @(negedge clk);
    nvec++;
    if ({tx[0], busy[0], done[0]} !== 3'b010) begin
      nerr++; $display("FAIL no_tick_hold: got tx/busy/done=%b want 010", {tx[0], busy[0], done[0]});
    end
    tick_en = 1'b1;
    watch(0, 144, b, da, be, t16, t32, ts, td);
    nvec++;
    if (b[9:0] !== {1'b1, 8'h5A, 1'b0} || da !== 160) begin
      nerr++; $display("FAIL no_tick_resume: got bits %b done@%0d want %b done@160",
                       b[9:0], da, {1'b1, 8'h5A, 1'b0});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      din[i]   = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    test_basic();
    test_patterns();
    test_parity();
    test_stop32();
    test_back_to_back();
    test_reset_mid();
    test_no_tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
